// File: rtl/local_bus_arbiter_if.sv
// Zorro local bus arbitration signal bundle.
// master: the arbiter; slave: host bus, NCR and slave decode side.
interface local_bus_arbiter_if;
    logic       FCS_n;
    logic       slave_cycle;
    logic       configured;
    logic       NCR_BR_n;
    logic       NCR_BGACK_n;
    logic       Z_BG_n;
    logic       Z_BR_n;
    logic       Z_BGACK_n;
    logic       NCR_BG_n;
    logic       slave_en;
    logic [1:0] bus_owner;
    logic       arb_timeout;

    modport master (
        input  FCS_n,
        input  slave_cycle,
        input  configured,
        input  NCR_BR_n,
        input  NCR_BGACK_n,
        input  Z_BG_n,
        output Z_BR_n,
        output Z_BGACK_n,
        output NCR_BG_n,
        output slave_en,
        output bus_owner,
        output arb_timeout
    );

    modport slave (
        output FCS_n,
        output slave_cycle,
        output configured,
        output NCR_BR_n,
        output NCR_BGACK_n,
        output Z_BG_n,
        input  Z_BR_n,
        input  Z_BGACK_n,
        input  NCR_BG_n,
        input  slave_en,
        input  bus_owner,
        input  arb_timeout
    );
endinterface

// File: rtl/local_bus_arbiter.sv
// Arbitrates the card's local bus between host slave cycles and NCR DMA.
// Define ARB_WATCHDOG_EN to add the REQ/GRANT watchdog (limit WD_LIMIT).
module local_bus_arbiter #(
    parameter logic [7:0] WD_LIMIT = 8'd200
) (
    input logic                 CLK,
    input logic                 RESET_n,
    local_bus_arbiter_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        SLAVE,
        REQ,
        GRANT,
        OWN,
        RELEASE
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic       last_ncr_q;
    logic       last_ncr_d;
    logic       timeout;
    logic       wd_hit;
    logic       slave_req;
    logic       ncr_req;
    logic       br_d;
    logic       bgack_d;
    logic       bg_d;
    logic       sen_d;
    logic [1:0] owner_d;

    assign slave_req = !bus.FCS_n & bus.slave_cycle & bus.configured;
    assign ncr_req   = !bus.NCR_BR_n;

`ifdef ARB_WATCHDOG_EN
    logic [7:0] wd_q;
    logic [7:0] wd_d;
    logic [7:0] wd_inc;

    assign wd_inc = wd_q + 8'd1;
    assign wd_hit = (wd_inc == WD_LIMIT);

    // Counter restarts whenever REQ or GRANT is (re)entered.
    always_comb begin
        wd_d = 8'd0;
        if ((state_q == REQ || state_q == GRANT) && state_d == state_q)
            wd_d = wd_inc;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_n)
            wd_q <= 8'd0;
        else
            wd_q <= wd_d;
    end
`else
    assign wd_hit = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            state_q    <= IDLE;
            last_ncr_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            last_ncr_q <= last_ncr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_ncr_d = last_ncr_q;
        timeout    = 1'b0;
        unique case (state_q)
            IDLE: begin
                // On a tie the previous owner yields.
                if (slave_req && ncr_req)
                    state_d = last_ncr_q ? SLAVE : REQ;
                else if (slave_req)
                    state_d = SLAVE;
                else if (ncr_req)
                    state_d = REQ;
            end
            SLAVE: begin
                last_ncr_d = 1'b0;
                if (bus.FCS_n)
                    state_d = IDLE;
            end
            REQ: begin
                if (!ncr_req) begin
                    state_d = IDLE;
                end else if (wd_hit) begin
                    state_d = IDLE;
                    timeout = 1'b1;
                end else if (!bus.Z_BG_n && bus.FCS_n) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!bus.NCR_BGACK_n) begin
                    state_d = OWN;
                end else if (wd_hit) begin
                    state_d = RELEASE;
                    timeout = 1'b1;
                end
            end
            OWN: begin
                last_ncr_d = 1'b1;
                if (bus.NCR_BGACK_n)
                    state_d = RELEASE;
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs follow the next state so they land on the same edge.
    always_comb begin
        br_d    = 1'b1;
        bgack_d = 1'b1;
        bg_d    = 1'b1;
        sen_d   = 1'b0;
        owner_d = 2'b00;
        unique case (state_d)
            SLAVE: begin
                sen_d   = 1'b1;
                owner_d = 2'b01;
            end
            REQ: br_d = 1'b0;
            GRANT: begin
                bgack_d = 1'b0;
                bg_d    = 1'b0;
                owner_d = 2'b10;
            end
            OWN: begin
                bgack_d = 1'b0;
                owner_d = 2'b10;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            bus.Z_BR_n      <= 1'b1;
            bus.Z_BGACK_n   <= 1'b1;
            bus.NCR_BG_n    <= 1'b1;
            bus.slave_en    <= 1'b0;
            bus.bus_owner   <= 2'b00;
            bus.arb_timeout <= 1'b0;
        end else begin
            bus.Z_BR_n      <= br_d;
            bus.Z_BGACK_n   <= bgack_d;
            bus.NCR_BG_n    <= bg_d;
            bus.slave_en    <= sen_d;
            bus.bus_owner   <= owner_d;
            bus.arb_timeout <= timeout;
        end
    end

endmodule

// File: doc/local_bus_arbiter.md
LOCAL_BUS_ARBITER -- requirements
Module: local_bus_arbiter

Interface
REQ-001 SHALL have parameter WD_LIMIT, default 8'd200: watchdog cycle limit in REQ/GRANT states.
REQ-002 SHALL have port CLK  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port RESET_n  input  1  synchronous active-low reset, sampled on the CLK rising edge.
REQ-004 SHALL have port FCS_n  input  1  Zorro full cycle strobe, active low.
REQ-005 SHALL have port slave_cycle  input  1  host slave access decoded to this card.
REQ-006 SHALL have port configured  input  1  autoconfig complete.
REQ-007 SHALL have port NCR_BR_n  input  1  NCR 53C710 bus request, active low.
REQ-008 SHALL have port NCR_BGACK_n  input  1  NCR bus-grant acknowledge, active low.
REQ-009 SHALL have port Z_BG_n  input  1  Zorro bus grant from host, active low.
REQ-010 SHALL have port Z_BR_n  output  1  Zorro bus request, active low.
REQ-011 SHALL have port Z_BGACK_n  output  1  card owns Zorro bus, active low.
REQ-012 SHALL have port NCR_BG_n  output  1  bus grant to NCR, active low.
REQ-013 SHALL have port slave_en  output  1  host slave access may proceed to local resources.
REQ-014 SHALL have port bus_owner  output  2  00 none, 01 slave, 10 NCR.
REQ-015 SHALL have port arb_timeout  output  1  one-cycle watchdog expiry pulse.

Function
REQ-016 SHALL register every output; responses appear one cycle after the sampled condition.
REQ-017 SHALL implement states IDLE, SLAVE, REQ, GRANT, OWN, RELEASE.
REQ-018 slave_req = !FCS_n & slave_cycle & configured; ncr_req = !NCR_BR_n.
REQ-019 IDLE, slave_req only -> SLAVE; ncr_req only -> REQ; neither -> stay.
REQ-020 IDLE, both requests same cycle -> grant the requester that was NOT last owner (round-robin via last_owner flag).
REQ-021 SLAVE: slave_en=1, bus_owner=01; exit to IDLE on FCS_n high; last_owner <= slave.
REQ-022 REQ: Z_BR_n=0; ncr_req drops before grant -> IDLE, Z_BR_n=1, no grant issued.
REQ-023 REQ, Z_BG_n low and FCS_n high -> GRANT; Z_BG_n low with FCS_n low waits in REQ (bus still busy).
REQ-024 GRANT: Z_BR_n=1, Z_BGACK_n=0, NCR_BG_n=0, bus_owner=10.
REQ-025 GRANT, NCR_BGACK_n low -> OWN; NCR_BG_n returns high on entry to OWN.
REQ-026 OWN: Z_BGACK_n=0, bus_owner=10; NCR_BGACK_n high -> RELEASE; last_owner <= NCR.
REQ-027 RELEASE: Z_BGACK_n=1, NCR_BG_n=1, bus_owner=00, exactly one cycle, then IDLE.
REQ-028 slave_req arriving in REQ/GRANT/OWN/RELEASE SHALL be held off (slave_en=0) and serviced from IDLE.
REQ-029 slave_en SHALL be 1 only in SLAVE; Z_BGACK_n and NCR_BG_n SHALL never be low while slave_en=1.

Reset
REQ-030 RESET_n low at a CLK edge SHALL force state IDLE, Z_BR_n=1, Z_BGACK_n=1, NCR_BG_n=1, slave_en=0, bus_owner=00, arb_timeout=0, watchdog=0, last_owner=NCR (slave wins first tie).
REQ-031 Reset mid-tenure (any state) SHALL release all bus signals on the same edge, with no RELEASE cycle.

Configuration
REQ-032 Macro ARB_WATCHDOG_EN defined: 8-bit counter clears on entry to REQ or GRANT, increments each cycle in them; reaching WD_LIMIT -> from REQ go IDLE, from GRANT go RELEASE, arb_timeout=1 for one cycle.
REQ-033 ARB_WATCHDOG_EN undefined: no counter, arb_timeout tied 0, REQ/GRANT wait indefinitely.

Verification
REQ-034 Slave read: slave_cycle=1, configured=1, FCS_n low 5 cycles -> slave_en=1, bus_owner=01 from cycle 2 until one cycle after FCS_n high.
REQ-035 NCR tenure: NCR_BR_n low, Z_BG_n low after 3 cycles, NCR_BGACK_n low 10 cycles -> Z_BR_n low, then Z_BGACK_n/NCR_BG_n low, NCR_BG_n high after ack, Z_BGACK_n high 1 cycle after ack release.
REQ-036 Tie after reset: slave_req and NCR_BR_n low same cycle -> SLAVE first; on tie after a slave tenure -> REQ first.
REQ-037 Abort: NCR_BR_n low 2 cycles then high, Z_BG_n high -> Z_BR_n low 2 cycles, NCR_BG_n never low, returns IDLE.
REQ-038 Watchdog (ARB_WATCHDOG_EN, WD_LIMIT=4): NCR_BR_n low, Z_BG_n held high -> arb_timeout pulse once, Z_BR_n high, state IDLE; macro undefined -> Z_BR_n stays low.
REQ-039 Reset in OWN: RESET_n low one cycle -> Z_BGACK_n=1, NCR_BG_n=1, bus_owner=00 the following cycle.
